// File: rtl/aes_spi_sequencer.sv
// Host-side sequencer that drives SPI_Main through one AES decrypt on the AES_Dencrypt slave:
// an optional key frame, then a ciphertext frame, then a readback frame that returns the plaintext.
module aes_spi_sequencer #(
  parameter int START_CYCLES   = 2,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req,
  input  logic [1:0]   key_size,
  input  logic [255:0] key,
  input  logic [127:0] data_in,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [127:0] result,
  output logic         spi_start,
  output logic [257:0] spi_tx,
  input  logic [127:0] spi_rx,
  input  logic         spi_done
);

  localparam int MAX_AB  = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX = (MAX_AB > START_CYCLES) ? MAX_AB : START_CYCLES;
  localparam int CW      = ($clog2(CNT_MAX + 1) > 13) ? $clog2(CNT_MAX + 1) : 13;

  localparam logic [CW-1:0] START_LAST   = CW'(START_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_TX,
    S_WAIT,
    S_GAP,
    S_FINISH,
    S_ABORT
  } state_t;

  typedef enum logic [1:0] {
    PH_KEY,
    PH_MSG,
    PH_READ
  } phase_t;

  state_t         state_q, state_d;
  phase_t         phase_q, phase_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           got_done_q, got_done_d;
  logic           accept;
  logic           complete;
  logic           xfer_done;
  logic           key_match;

  logic [1:0]     ks_q;
  logic [255:0]   key_q;
  logic [127:0]   data_q;
  logic [1:0]     cache_ks;
  logic [255:0]   cache_key;
  logic           key_loaded;
  logic [127:0]   result_q;

  assign key_match = (ks_q == cache_ks) && (key_q == cache_key);
  assign xfer_done = spi_done && ((state_q == S_TX) || (state_q == S_WAIT));

  // The counter starts at the first spi_start cycle and keeps running through WAIT,
  // so the same count serves both the start burst length and the transfer timeout.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q + CW'(1);
    got_done_d = got_done_q;
    accept     = 1'b0;
    complete   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d      = '0;
        got_done_d = 1'b0;
        if (req) begin
          accept  = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        cnt_d = '0;
        if (ks_q == 2'b11) begin
          state_d = S_ABORT;
        end else if (key_loaded && key_match) begin
          phase_d = PH_MSG;
          state_d = S_TX;
        end else begin
          phase_d = PH_KEY;
          state_d = S_TX;
        end
      end
      S_TX: begin
        if (spi_done) got_done_d = 1'b1;
        if (cnt_q == START_LAST) begin
          if (got_done_q || spi_done) complete = 1'b1;
          else                        state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (spi_done)                   complete = 1'b1;
        else if (cnt_q == TIMEOUT_LAST) state_d  = S_ABORT;
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_TX;
          cnt_d   = '0;
        end
      end
      S_FINISH: state_d = S_IDLE;
      S_ABORT:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (complete) begin
      cnt_d      = '0;
      got_done_d = 1'b0;
      unique case (phase_q)
        PH_KEY: begin
          phase_d = PH_MSG;
          state_d = (GAP_CYCLES == 0) ? S_TX : S_GAP;
        end
        PH_MSG: begin
          phase_d = PH_READ;
          state_d = (GAP_CYCLES == 0) ? S_TX : S_GAP;
        end
        default: state_d = S_FINISH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      phase_q    <= PH_KEY;
      cnt_q      <= '0;
      got_done_q <= 1'b0;
      ks_q       <= '0;
      key_q      <= '0;
      data_q     <= '0;
      cache_ks   <= '0;
      cache_key  <= '0;
      key_loaded <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      got_done_q <= got_done_d;
      if (accept) begin
        ks_q   <= key_size;
        key_q  <= key;
        data_q <= data_in;
      end
      if (xfer_done && (phase_q == PH_KEY)) begin
        cache_ks   <= ks_q;
        cache_key  <= key_q;
        key_loaded <= 1'b1;
      end
      if (xfer_done && (phase_q == PH_READ)) result_q <= spi_rx;
      // After an illegal size or a timeout the slave's key state cannot be trusted.
      if (state_q == S_ABORT) key_loaded <= 1'b0;
    end
  end

  always_comb begin
    spi_tx = '0;
    if ((state_q == S_TX) || (state_q == S_WAIT)) begin
      unique case (phase_q)
        PH_KEY:  spi_tx = {ks_q, key_q};
        PH_MSG:  spi_tx = {130'b0, data_q};
        default: spi_tx = '0;
      endcase
    end
  end

  assign busy      = (state_q == S_CHECK) || (state_q == S_TX) ||
                     (state_q == S_WAIT)  || (state_q == S_GAP);
  assign done      = (state_q == S_FINISH);
  assign error     = (state_q == S_ABORT);
  assign spi_start = (state_q == S_TX);
  assign result    = result_q;

endmodule

// File: tb/tb_aes_spi_sequencer.sv
// Directed bench for aes_spi_sequencer with a behavioural SPI_Main stub that logs every frame
// and answers the readback frame with a preset plaintext.
module tb_aes_spi_sequencer;

  localparam int TIMEOUT = 4096;

  localparam logic [255:0] KEY128 = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] KEY192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] JUNK   = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req = 1'b0;
  logic [1:0]   key_size = 2'b00;
  logic [255:0] key = '0;
  logic [127:0] data_in = '0;
  logic         busy, done, error;
  logic [127:0] result;
  logic         spi_start;
  logic [257:0] spi_tx;
  logic [127:0] spi_rx = '0;
  logic         spi_done = 1'b0;

  int total = 0;
  int bad = 0;

  int           bursts = 0;
  int           n_frames = 0;
  logic [257:0] frame_log [8];
  bit           stub_on = 1'b1;
  int           stub_delay = 4;
  logic [127:0] rx_value = '0;
  logic         prev_start = 1'b0;
  bit           pending = 1'b0;
  bit           pending_read = 1'b0;
  int           dly = 0;

  aes_spi_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .key_size  (key_size),
    .key       (key),
    .data_in   (data_in),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .result    (result),
    .spi_start (spi_start),
    .spi_tx    (spi_tx),
    .spi_rx    (spi_rx),
    .spi_done  (spi_done)
  );

  always #5 clk = ~clk;

  // SPI stub works on the falling edge so its outputs are stable for the DUT's rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      spi_done   = 1'b0;
      pending    = 1'b0;
      prev_start = 1'b0;
    end else begin
      spi_done = 1'b0;
      if (pending) begin
        if (dly == 0) begin
          spi_done = 1'b1;
          spi_rx   = pending_read ? rx_value : JUNK;
          pending  = 1'b0;
        end else begin
          dly--;
        end
      end
      if (spi_start && !prev_start) begin
        bursts++;
        if (n_frames < 8) frame_log[n_frames] = spi_tx;
        n_frames++;
        if (stub_on) begin
          pending      = 1'b1;
          pending_read = (spi_tx == '0);
          dly          = stub_delay;
        end
      end
      prev_start = spi_start;
    end
  end

  task automatic run_op(input string name, input logic [1:0] ks, input logic [255:0] k,
                        input logic [127:0] d, input int exp_bursts, input bit spam);
    int  b0;
    int  cyc;
    bit  seen;
    @(negedge clk);
    key_size = ks;
    key      = k;
    data_in  = d;
    rx_value = PT;
    n_frames = 0;
    b0       = bursts;
    req      = 1'b1;
    @(negedge clk);
    req = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s busy_after_req: got %b expected 1", name, busy);
    end
    key      = ~k;
    data_in  = ~d;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
      else if (spam) req = ((cyc % 3) == 0);
    end
    req = 1'b0;
    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL %s done_timeout: got no done after %0d cycles expected done", name, cyc);
    end else begin
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("[TB] FAIL %s busy_on_done: got %b expected 0", name, busy);
      end
      total++;
      if (result !== PT) begin
        bad++;
        $display("[TB] FAIL %s result: got %h expected %h", name, result, PT);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0) begin
        bad++;
        $display("[TB] FAIL %s done_width: got %b expected 0", name, done);
      end
    end
    repeat (30) @(negedge clk);
    total++;
    if (bursts - b0 != exp_bursts) begin
      bad++;
      $display("[TB] FAIL %s burst_count: got %0d expected %0d", name, bursts - b0, exp_bursts);
    end
    total++;
    if (result !== PT) begin
      bad++;
      $display("[TB] FAIL %s result_held: got %h expected %h", name, result, PT);
    end
    if (exp_bursts == 3) begin
      total++;
      if (frame_log[0] !== {ks, k}) begin
        bad++;
        $display("[TB] FAIL %s key_frame: got %h expected %h", name, frame_log[0], {ks, k});
      end
      total++;
      if (frame_log[1] !== {130'b0, d}) begin
        bad++;
        $display("[TB] FAIL %s msg_frame: got %h expected %h", name, frame_log[1], {130'b0, d});
      end
      total++;
      if (frame_log[2] !== '0) begin
        bad++;
        $display("[TB] FAIL %s read_frame: got %h expected 0", name, frame_log[2]);
      end
    end else begin
      total++;
      if (frame_log[0] !== {130'b0, d}) begin
        bad++;
        $display("[TB] FAIL %s msg_frame: got %h expected %h", name, frame_log[0], {130'b0, d});
      end
      total++;
      if (frame_log[1] !== '0) begin
        bad++;
        $display("[TB] FAIL %s read_frame: got %h expected 0", name, frame_log[1]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, error, spi_start} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_flags: got %b expected 0000", {busy, done, error, spi_start});
    end
    total++;
    if (spi_tx !== '0 || result !== '0) begin
      bad++;
      $display("[TB] FAIL reset_data: got tx=%h res=%h expected 0", spi_tx, result);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || spi_start !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_idle: got busy=%b start=%b expected 0", busy, spi_start);
    end
  endtask

  task automatic test_aes128();
    stub_delay = 4;
    run_op("aes128", 2'b00, KEY128, CT128, 3, 1'b0);
  endtask

  task automatic test_repeat_same_key();
    stub_delay = 0;
    run_op("aes128_cached", 2'b00, KEY128, CT128, 2, 1'b0);
    stub_delay = 4;
  endtask

  task automatic test_key_sizes();
    run_op("aes192", 2'b01, KEY192, CT192, 3, 1'b0);
    run_op("aes256", 2'b10, KEY256, CT256, 3, 1'b0);
    run_op("aes256_cached", 2'b10, KEY256, CT256, 2, 1'b0);
  endtask

  task automatic test_illegal_size();
    int b0;
    int cyc;
    bit seen;
    @(negedge clk);
    key_size = 2'b11;
    key      = KEY256;
    data_in  = CT256;
    b0       = bursts;
    req      = 1'b1;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 10) begin
      @(negedge clk);
      req = 1'b0;
      cyc++;
      if (error) seen = 1'b1;
    end
    total++;
    if (!seen || cyc > 2) begin
      bad++;
      $display("[TB] FAIL illegal_error_latency: got seen=%b cycles=%0d expected error within 2", seen, cyc);
    end
    @(negedge clk);
    total++;
    if (error !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL illegal_after: got error=%b busy=%b expected 0 0", error, busy);
    end
    repeat (30) @(negedge clk);
    total++;
    if (bursts != b0) begin
      bad++;
      $display("[TB] FAIL illegal_no_spi: got %0d bursts expected 0", bursts - b0);
    end
    run_op("aes256_after_illegal", 2'b10, KEY256, CT256, 3, 1'b0);
  endtask

  task automatic test_timeout();
    int  cyc;
    int  t0;
    int  t1;
    bit  saw_done;
    stub_on = 1'b0;
    @(negedge clk);
    key_size = 2'b10;
    key      = KEY256;
    data_in  = CT256;
    n_frames = 0;
    req      = 1'b1;
    cyc = 0;
    t0  = -1;
    t1  = -1;
    saw_done = 1'b0;
    while (t1 < 0 && cyc < 5000) begin
      @(negedge clk);
      req = 1'b0;
      cyc++;
      if (spi_start && t0 < 0) t0 = cyc;
      if (error) t1 = cyc;
      if (done) saw_done = 1'b1;
    end
    total++;
    if (t1 < 0 || t0 < 0 || (t1 - t0) != TIMEOUT) begin
      bad++;
      $display("[TB] FAIL timeout_delay: got start=%0d error=%0d delta=%0d expected %0d", t0, t1, t1 - t0, TIMEOUT);
    end
    total++;
    if (saw_done) begin
      bad++;
      $display("[TB] FAIL timeout_no_done: got done pulse expected none");
    end
    total++;
    if (frame_log[0] !== {130'b0, CT256}) begin
      bad++;
      $display("[TB] FAIL timeout_frame: got %h expected %h", frame_log[0], {130'b0, CT256});
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || error !== 1'b0) begin
      bad++;
      $display("[TB] FAIL timeout_after: got busy=%b error=%b expected 0 0", busy, error);
    end
    stub_on = 1'b1;
    run_op("resend_after_timeout", 2'b10, KEY256, CT256, 3, 1'b0);
  endtask

  task automatic test_reset_mid_op();
    int b0;
    int cyc;
    stub_delay = 8;
    @(negedge clk);
    key_size = 2'b10;
    key      = KEY256;
    data_in  = CT256;
    b0       = bursts;
    req      = 1'b1;
    cyc = 0;
    @(negedge clk);
    req = 1'b0;
    while (!((bursts - b0) == 1 && !spi_start) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, error, spi_start} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL midreset_flags: got %b expected 0000", {busy, done, error, spi_start});
    end
    total++;
    if (spi_tx !== '0 || result !== '0) begin
      bad++;
      $display("[TB] FAIL midreset_data: got tx=%h res=%h expected 0", spi_tx, result);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stub_delay = 4;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    run_op("reload_with_busy_req", 2'b10, KEY256, CT256, 3, 1'b1);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL busy_req_not_queued: got busy=%b expected 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_aes128();
    test_repeat_same_key();
    test_key_sizes();
    test_illegal_size();
    test_timeout();
    test_reset_mid_op();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
